// File: rtl/aes_inv_pkg.sv
// aes_inv_pkg: shared FSM type, constants and GF(2^8) helpers for the AES-128 inverse cipher
package aes_inv_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} st_e;

    localparam int NR = 10;
    localparam int KEY_IDX_W = 4;

    function automatic int bidx(input int r, input int c);
        return 127 - 8 * (4 * r + c);
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul9(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ b;
    endfunction

    function automatic logic [7:0] gmul11(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
    endfunction

    function automatic logic [7:0] gmul13(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
    endfunction

    function automatic logic [7:0] gmul14(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            p = b[i] ? p ^ x : p;
            x = xtime(x);
        end
        return p;
    endfunction

    // Inverse affine transform followed by the multiplicative inverse t^254 (0 maps to 0).
    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        logic [7:0] t;
        logic [7:0] sq;
        logic [7:0] r;
        t = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
        sq = t;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r = gf_mul(r, sq);
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_inv_cipher_core_shift_rows.sv
// aes_inv_shift_rows: row r of the row-major state rotates right by r bytes
module aes_inv_shift_rows
    import aes_inv_pkg::*;
(
    input  logic [127:0] data_in,
    output logic [127:0] data_out
);

    for (genvar r = 0; r < 4; r++) begin : g_row
        for (genvar c = 0; c < 4; c++) begin : g_col
            assign data_out[bidx(r, c) -: 8] = data_in[bidx(r, (c - r + 4) % 4) -: 8];
        end
    end

endmodule

// File: rtl/aes_inv_cipher_core.sv
// aes_inv_cipher_core: iterative AES-128 decryption, one inverse round per clock
module aes_inv_cipher_core
    import aes_inv_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [127:0]         ct_in,
    input  logic [127:0]         round_key,
    output logic [KEY_IDX_W-1:0] key_idx,
    output logic                 busy,
    output logic                 done,
    output logic [127:0]         pt_out
);

    st_e st_q, st_d;
    logic [KEY_IDX_W-1:0] rnd_q, rnd_d;
    logic [127:0] state_q, state_d, pt_q, pt_d;
    logic [127:0] sr, sb, ark, mc;

    aes_inv_shift_rows u_shift_rows (.data_in(state_q), .data_out(sr));

    for (genvar i = 0; i < 16; i++) begin : g_sub
        assign sb[127 - 8 * i -: 8] = inv_sbox(sr[127 - 8 * i -: 8]);
    end

    assign ark = sb ^ round_key;

    for (genvar c = 0; c < 4; c++) begin : g_mix
        logic [7:0] a0, a1, a2, a3;
        assign a0 = ark[bidx(0, c) -: 8];
        assign a1 = ark[bidx(1, c) -: 8];
        assign a2 = ark[bidx(2, c) -: 8];
        assign a3 = ark[bidx(3, c) -: 8];
        assign mc[bidx(0, c) -: 8] = gmul14(a0) ^ gmul11(a1) ^ gmul13(a2) ^ gmul9(a3);
        assign mc[bidx(1, c) -: 8] = gmul9(a0) ^ gmul14(a1) ^ gmul11(a2) ^ gmul13(a3);
        assign mc[bidx(2, c) -: 8] = gmul13(a0) ^ gmul9(a1) ^ gmul14(a2) ^ gmul11(a3);
        assign mc[bidx(3, c) -: 8] = gmul11(a0) ^ gmul13(a1) ^ gmul9(a2) ^ gmul14(a3);
    end

    always_comb begin
        st_d = st_q;
        rnd_d = rnd_q;
        state_d = state_q;
        pt_d = pt_q;
        case (st_q)
            IDLE, DONE: begin
                st_d = start ? RUN : IDLE;
                rnd_d = start ? KEY_IDX_W'(NR - 1) : rnd_q;
                state_d = start ? ct_in ^ round_key : state_q;
            end
            RUN: begin
                st_d = (rnd_q == '0) ? DONE : RUN;
                rnd_d = (rnd_q == '0) ? rnd_q : rnd_q - 1'b1;
                state_d = (rnd_q == '0) ? ark : mc;
                pt_d = (rnd_q == '0) ? ark : pt_q;
            end
            default: st_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q <= IDLE;
            rnd_q <= '0;
            state_q <= '0;
            pt_q <= '0;
        end else begin
            st_q <= st_d;
            rnd_q <= rnd_d;
            state_q <= state_d;
            pt_q <= pt_d;
        end
    end

    assign busy = (st_q == RUN);
    assign done = (st_q == DONE);
    assign key_idx = busy ? rnd_q : KEY_IDX_W'(NR);
    assign pt_out = pt_q;

endmodule

// File: tb/tb_aes_inv_cipher_core.sv
// tb_aes_inv_cipher_core: directed FIPS-197 C.1 decryption vectors against a bench-side key store
module tb_aes_inv_cipher_core;

    logic clk = 1'b0;
    logic rst, start, busy, done;
    logic [127:0] ct_in, round_key, pt_out, sr_in, sr_out;
    logic [3:0] key_idx;
    int n_chk = 0;
    int n_pass = 0;

    localparam logic [127:0] CT   = 128'h696ad870_c47bcdb4_e004b7c5_d830805a;
    localparam logic [127:0] PT   = 128'h004488cc_115599dd_2266aaee_3377bbff;
    localparam logic [127:0] JUNK = 128'h01234567_89abcdef_fedcba98_76543210;

    // FIPS-197 C.1 key schedule for key 000102..0f, in standard column-major byte order
    logic [127:0] rk_cm [11] = '{
        128'h000102030405060708090a0b0c0d0e0f,
        128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
        128'hb692cf0b643dbdf1be9bc5006830b3fe,
        128'hb6ff744ed2c2c9bf6c590cbf0469bf41,
        128'h47f7f7bc95353e03f96c32bcfd058dfd,
        128'h3caaa3e8a99f9deb50f3af57adf622aa,
        128'h5e390f7df7a69296a7553dc10aa31f6b,
        128'h14f9701ae35fe28c440adf4d4ea9c026,
        128'h47438735a41c65b9e016baf4aebf7ad2,
        128'h549932d1f08557681093ed9cbe2c974e,
        128'h13111d7fe3944a17f307a78b4d2b30c5
    };

    function automatic logic [127:0] to_rm(input logic [127:0] cm);
        logic [127:0] rm;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                rm[127 - 8 * (4 * r + c) -: 8] = cm[127 - 8 * (4 * c + r) -: 8];
        return rm;
    endfunction

    assign round_key = (key_idx <= 4'd10) ? to_rm(rk_cm[key_idx]) : '0;

    aes_inv_cipher_core dut (
        .clk(clk), .rst(rst), .start(start), .ct_in(ct_in), .round_key(round_key),
        .key_idx(key_idx), .busy(busy), .done(done), .pt_out(pt_out)
    );

    aes_inv_shift_rows u_sr (.data_in(sr_in), .data_out(sr_out));

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
        else n_pass++;
    endtask

    int ndone, c1, c2, cnt;
    logic [127:0] p1, p2;

    initial begin
        rst = 1'b1;
        start = 1'b0;
        ct_in = '0;
        sr_in = 128'h00010203_04050607_08090a0b_0c0d0e0f;
        tick;
        tick;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pt", pt_out, 0);
        check("rst_kidx", key_idx, 10);
        check("inv_shift_rows", sr_out, 128'h00010203_07040506_0a0b0809_0d0e0f0c);
        rst = 1'b0;

        // known answer with key index and busy sequencing
        ct_in = CT;
        start = 1'b1;
        check("kidx_pre", key_idx, 10);
        tick;
        start = 1'b0;
        ct_in = JUNK;
        for (int i = 0; i < 10; i++) begin
            check($sformatf("kidx_T%0d", i + 1), key_idx, 9 - i);
            check($sformatf("busy_T%0d", i + 1), busy, 1);
            check($sformatf("done_T%0d", i + 1), done, 0);
            tick;
        end
        check("kat_done", done, 1);
        check("kat_pt", pt_out, PT);
        check("kidx_post", key_idx, 10);
        check("busy_post", busy, 0);
        tick;
        check("done_pulse", done, 0);
        check("pt_hold", pt_out, PT);

        // start during RUN is ignored
        ct_in = CT;
        start = 1'b1;
        tick;
        ndone = 0;
        c1 = 0;
        p1 = '0;
        for (int cyc = 1; cyc <= 16; cyc++) begin
            if (done) begin ndone++; c1 = cyc; p1 = pt_out; end
            start = (cyc == 4);
            ct_in = (cyc == 4) ? JUNK : CT;
            tick;
        end
        check("ign_ndone", ndone, 1);
        check("ign_cycle", c1, 11);
        check("ign_pt", p1, PT);

        // reset mid-operation discards the block
        ct_in = JUNK;
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_pt", pt_out, 0);
        check("mid_rst_kidx", key_idx, 10);
        ndone = 0;
        for (int i = 0; i < 15; i++) begin
            if (done) ndone++;
            tick;
        end
        check("mid_rst_nodone", ndone, 0);
        ct_in = CT;
        start = 1'b1;
        tick;
        start = 1'b0;
        cnt = 1;
        while (!done && cnt < 20) begin tick; cnt++; end
        check("post_rst_latency", cnt, 11);
        check("post_rst_pt", pt_out, PT);
        tick;

        // back-to-back with start held; second ct_in valid only in the DONE cycle
        ct_in = CT;
        start = 1'b1;
        tick;
        ndone = 0;
        c1 = 0;
        c2 = 0;
        p1 = '0;
        p2 = '0;
        for (int cyc = 1; cyc <= 24; cyc++) begin
            if (done) begin
                ndone++;
                if (ndone == 1) begin c1 = cyc; p1 = pt_out; end
                if (ndone == 2) begin c2 = cyc; p2 = pt_out; end
            end
            ct_in = (cyc == 11) ? CT : JUNK;
            tick;
        end
        start = 1'b0;
        check("b2b_ndone", ndone, 2);
        check("b2b_cycle1", c1, 11);
        check("b2b_cycle2", c2, 22);
        check("b2b_pt1", p1, PT);
        check("b2b_pt2", p2, PT);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
